// File: rtl/hamming_secded_decoder_if.sv
// Stream and status bundle for hamming_secded_decoder.
//   in_valid / in_ready / in_codeword     : 16-bit codeword input stream
//   out_valid / out_ready / out_data      : 11-bit decoded message output stream
//   out_err_corrected / out_err_uncorrectable / out_syndrome : per-word status
//   clr_counts                            : synchronous clear of both error counters
//   corr_count / uncorr_count             : saturating error counters (CNT_W bits)
// master = producer/consumer side, slave = decoder side.
interface hamming_secded_decoder_if #(
    parameter int unsigned CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_codeword;
    logic             out_valid;
    logic             out_ready;
    logic [10:0]      out_data;
    logic             out_err_corrected;
    logic             out_err_uncorrectable;
    logic [3:0]       out_syndrome;
    logic             clr_counts;
    logic [CNT_W-1:0] corr_count;
    logic [CNT_W-1:0] uncorr_count;

    modport master (
        output in_valid, in_codeword, out_ready, clr_counts,
        input  in_ready, out_valid, out_data, out_err_corrected,
               out_err_uncorrectable, out_syndrome, corr_count, uncorr_count
    );

    modport slave (
        input  in_valid, in_codeword, out_ready, clr_counts,
        output in_ready, out_valid, out_data, out_err_corrected,
               out_err_uncorrectable, out_syndrome, corr_count, uncorr_count
    );
endinterface

// File: rtl/hamming_secded_decoder.sv
// Two-stage pipelined extended-Hamming (16,11) SECDED decoder.
// Stage 1 registers the codeword with its syndrome and overall parity;
// stage 2 corrects/classifies and registers the result onto the outputs.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : hamming_secded_decoder_if.slave (input/output streams, status, counters)
module hamming_secded_decoder #(
    parameter int unsigned CNT_W = 16
) (
    input logic                       clk,
    input logic                       rst,
    hamming_secded_decoder_if.slave   bus
);
    localparam int unsigned CW_W   = 16;
    localparam int unsigned DATA_W = 11;
    localparam int unsigned SYN_W  = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Syndrome: bit k is the XOR of every codeword bit whose index has bit k set.
    function automatic logic [SYN_W-1:0] calc_syndrome(input logic [CW_W-1:0] cw);
        logic [SYN_W-1:0] syn;
        logic [SYN_W-1:0] idx;
        syn = '0;
        for (int i = 0; i < int'(CW_W); i++) begin
            idx = SYN_W'(i);
            for (int k = 0; k < int'(SYN_W); k++) begin
                if (idx[k]) syn[k] = syn[k] ^ cw[i];
            end
        end
        return syn;
    endfunction

    logic              s1_valid;
    logic [CW_W-1:0]   s1_cw;
    logic [SYN_W-1:0]  s1_syn;
    logic              s1_p;

    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_corr_q;
    logic              out_uncorr_q;
    logic [SYN_W-1:0]  out_syn_q;
    logic [CNT_W-1:0]  corr_q;
    logic [CNT_W-1:0]  uncorr_q;

    logic              s2_adv;
    logic              s1_adv;
    logic              out_xfer;
    logic [SYN_W-1:0]  in_syn;
    logic              in_p;
    logic [CW_W-1:0]   flip_mask;
    logic [CW_W-1:0]   fixed_cw;
    logic [DATA_W-1:0] s2_data;
    logic              s2_corr;
    logic              s2_uncorr;

    // Pipeline advance conditions; in_ready has no skid buffer behind it.
    always_comb begin
        s2_adv   = !out_valid_q || bus.out_ready;
        s1_adv   = !s1_valid || s2_adv;
        out_xfer = out_valid_q && bus.out_ready;
    end

    assign bus.in_ready = !rst && s1_adv;

    always_comb begin
        in_syn = calc_syndrome(bus.in_codeword);
        in_p   = ^bus.in_codeword;
    end

    // Stage 1: capture codeword, syndrome and overall parity.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_cw    <= '0;
            s1_syn   <= '0;
            s1_p     <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_cw  <= bus.in_codeword;
                s1_syn <= in_syn;
                s1_p   <= in_p;
            end
        end
    end

    // Odd overall parity means a single error at index s (s==0 is the parity bit
    // itself); even parity with s!=0 is a double error and the word is left raw.
    always_comb begin
        flip_mask = '0;
        if (s1_p) flip_mask = CW_W'(1) << s1_syn;
        fixed_cw  = s1_cw ^ flip_mask;
        s2_data   = {fixed_cw[15:9], fixed_cw[7:5], fixed_cw[3]};
        s2_corr   = s1_p;
        s2_uncorr = !s1_p && (s1_syn != '0);
    end

    // Stage 2: output registers, held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_corr_q   <= 1'b0;
            out_uncorr_q <= 1'b0;
            out_syn_q    <= '0;
        end else if (s2_adv) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                out_data_q   <= s2_data;
                out_corr_q   <= s2_corr;
                out_uncorr_q <= s2_uncorr;
                out_syn_q    <= s1_syn;
            end
        end
    end

    // Saturating counters of delivered words; a clear beats a coincident increment.
    always_ff @(posedge clk) begin
        if (rst || bus.clr_counts) begin
            corr_q   <= '0;
            uncorr_q <= '0;
        end else if (out_xfer) begin
            if (out_corr_q && (corr_q != CNT_MAX))     corr_q   <= corr_q + CNT_W'(1);
            if (out_uncorr_q && (uncorr_q != CNT_MAX)) uncorr_q <= uncorr_q + CNT_W'(1);
        end
    end

    assign bus.out_valid             = out_valid_q;
    assign bus.out_data              = out_data_q;
    assign bus.out_err_corrected     = out_corr_q;
    assign bus.out_err_uncorrectable = out_uncorr_q;
    assign bus.out_syndrome          = out_syn_q;
    assign bus.corr_count            = corr_q;
    assign bus.uncorr_count          = uncorr_q;
endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Directed self-checking bench for hamming_secded_decoder.
// Two instances share one stimulus stream: CNT_W=16 (dut_a) and CNT_W=2 (dut_b).
module tb_hamming_secded_decoder;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_codeword;
    logic        out_ready;
    logic        clr_counts;

    int n_checks;
    int n_fail;

    hamming_secded_decoder_if #(.CNT_W(16)) a ();
    hamming_secded_decoder_if #(.CNT_W(2))  b ();

    assign a.in_valid    = in_valid;
    assign a.in_codeword = in_codeword;
    assign a.out_ready   = out_ready;
    assign a.clr_counts  = clr_counts;
    assign b.in_valid    = in_valid;
    assign b.in_codeword = in_codeword;
    assign b.out_ready   = out_ready;
    assign b.clr_counts  = clr_counts;

    hamming_secded_decoder #(.CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(a.slave));
    hamming_secded_decoder #(.CNT_W(2))  dut_b (.clk(clk), .rst(rst), .bus(b.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Send one word with out_ready high and check the result two edges later.
    task automatic push_check(input string tag, input logic [15:0] cw, input logic [10:0] d,
                              input logic c, input logic u, input logic [3:0] s);
        in_valid    = 1'b1;
        in_codeword = cw;
        step();
        in_valid = 1'b0;
        step();
        chk({tag, "_valid"},  32'(a.out_valid), 32'd1);
        chk({tag, "_data"},   32'(a.out_data), 32'(d));
        chk({tag, "_corr"},   32'(a.out_err_corrected), 32'(c));
        chk({tag, "_uncorr"}, 32'(a.out_err_uncorrectable), 32'(u));
        chk({tag, "_syn"},    32'(a.out_syndrome), 32'(s));
        step();
        chk({tag, "_drain"},  32'(a.out_valid), 32'd0);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_codeword = 16'h0000;
        out_ready   = 1'b1;
        clr_counts  = 1'b0;
        step();
        step();
        chk("rst_in_ready",  32'(a.in_ready), 32'd0);
        chk("rst_out_valid", 32'(a.out_valid), 32'd0);
        chk("rst_data",      32'(a.out_data), 32'd0);
        chk("rst_syn",       32'(a.out_syndrome), 32'd0);
        chk("rst_flags",     32'({a.out_err_corrected, a.out_err_uncorrectable}), 32'd0);
        chk("rst_corr_cnt",  32'(a.corr_count), 32'd0);
        chk("rst_unc_cnt",   32'(a.uncorr_count), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(a.in_ready), 32'd1);

        // Clean, single-error, parity-bit error, double-error words.
        push_check("clean_ffff", 16'hFFFF, 11'h7FF, 1'b0, 1'b0, 4'h0);
        chk("clean_corr_cnt", 32'(a.corr_count), 32'd0);
        chk("clean_unc_cnt",  32'(a.uncorr_count), 32'd0);
        push_check("sec_ffbf", 16'hFFBF, 11'h7FF, 1'b1, 1'b0, 4'h6);
        chk("sec_corr_cnt", 32'(a.corr_count), 32'd1);
        push_check("sec_bit0", 16'h000E, 11'h001, 1'b1, 1'b0, 4'h0);
        chk("bit0_corr_cnt", 32'(a.corr_count), 32'd2);
        push_check("ded_0028", 16'h0028, 11'h003, 1'b0, 1'b1, 4'h6);
        chk("ded_unc_cnt",  32'(a.uncorr_count), 32'd1);
        chk("ded_corr_cnt", 32'(a.corr_count), 32'd2);
        chk("ded_unc_cnt_b", 32'(b.uncorr_count), 32'd1);

        // Backpressure: two words fill the pipe, the third waits.
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        in_codeword = 16'h0000;
        #1;
        chk("bp_ready0", 32'(a.in_ready), 32'd1);
        step();
        in_codeword = 16'h000F;
        #1;
        chk("bp_ready1", 32'(a.in_ready), 32'd1);
        step();
        in_codeword = 16'hFFFF;
        #1;
        chk("bp_ready2",  32'(a.in_ready), 32'd0);
        chk("bp_valid",   32'(a.out_valid), 32'd1);
        chk("bp_data0",   32'(a.out_data), 32'h000);
        step();
        chk("bp_hold_valid", 32'(a.out_valid), 32'd1);
        chk("bp_hold_data",  32'(a.out_data), 32'h000);
        chk("bp_hold_ready", 32'(a.in_ready), 32'd0);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(a.in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("bp_data1", 32'(a.out_data), 32'h001);
        chk("bp_valid1", 32'(a.out_valid), 32'd1);
        step();
        chk("bp_data2", 32'(a.out_data), 32'h7FF);
        chk("bp_valid2", 32'(a.out_valid), 32'd1);
        step();
        chk("bp_drain", 32'(a.out_valid), 32'd0);
        chk("bp_corr_cnt", 32'(a.corr_count), 32'd2);

        // Three more corrected words: 5 total, 2-bit counter saturates at 3.
        for (int i = 0; i < 3; i++) begin
            push_check("sat_word", 16'hFFBF, 11'h7FF, 1'b1, 1'b0, 4'h6);
        end
        chk("sat_corr_cnt_a", 32'(a.corr_count), 32'd5);
        chk("sat_corr_cnt_b", 32'(b.corr_count), 32'd3);

        // Clear coinciding with a corrected-word transfer: clear wins.
        in_valid    = 1'b1;
        in_codeword = 16'hFFBF;
        step();
        in_valid = 1'b0;
        step();
        chk("clr_out_valid", 32'(a.out_valid), 32'd1);
        clr_counts = 1'b1;
        step();
        clr_counts = 1'b0;
        chk("clr_corr_a", 32'(a.corr_count), 32'd0);
        chk("clr_corr_b", 32'(b.corr_count), 32'd0);
        chk("clr_unc_a",  32'(a.uncorr_count), 32'd0);
        step();
        chk("clr_stays_a", 32'(a.corr_count), 32'd0);

        // Reset with two words in flight discards both.
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        in_codeword = 16'h0028;
        step();
        in_codeword = 16'hFFBF;
        step();
        in_valid = 1'b0;
        chk("flight_valid", 32'(b.out_valid), 32'd1);
        rst = 1'b1;
        step();
        chk("flush_valid",    32'(b.out_valid), 32'd0);
        chk("flush_in_ready", 32'(b.in_ready), 32'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        step();
        chk("flush_none1", 32'(b.out_valid), 32'd0);
        step();
        chk("flush_none2", 32'(b.out_valid), 32'd0);
        chk("flush_corr_b", 32'(b.corr_count), 32'd0);
        chk("flush_unc_b",  32'(b.uncorr_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
